// File: rtl/iomux_ctrl.sv
// Runtime pin-mux for shared user-area pads: per-pad function select with a
// tri-state guard interval whenever a pad changes owner.
module iomux_ctrl #(
  parameter int unsigned N_PADS    = 5,
  parameter int unsigned N_FUNC    = 3,
  parameter int unsigned GUARD_CYC = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       reg_req_i,
  input  logic                       reg_we_i,
  input  logic [1:0]                 reg_addr_i,
  input  logic [31:0]                reg_wdata_i,
  output logic [31:0]                reg_rdata_o,
  output logic                       reg_ack_o,
  input  logic [N_PADS*N_FUNC-1:0]   func_out_i,
  input  logic [N_PADS*N_FUNC-1:0]   func_oe_i,
  output logic [N_PADS*N_FUNC-1:0]   func_in_o,
  input  logic [N_PADS-1:0]          pad_in_i,
  output logic [N_PADS-1:0]          pad_out_o,
  output logic [N_PADS-1:0]          pad_oeb_o
);

  localparam logic [2:0] NFuncW  = 3'(N_FUNC);
  localparam logic [3:0] GuardLd = 4'(GUARD_CYC);

  typedef enum logic {StActive, StGuard} pad_st_e;

  logic              ack_q;
  logic [31:0]       rdata_q;
  logic              lock_q;
  logic [31:0]       rd_data;
  logic              accept;
  logic              sel_wr;
  logic [N_PADS-1:0] status;
  logic [31:0]       pend_all;

  // An access is taken only while no ack is pending, giving the one-cycle ack pulse.
  assign accept = reg_req_i & ~ack_q;
  assign sel_wr = accept & reg_we_i & (reg_addr_i == 2'd0) & ~lock_q;

  always_comb begin
    rd_data = '0;
    unique case (reg_addr_i)
      2'd0:    rd_data = pend_all;
      2'd1:    rd_data[0] = lock_q;
      2'd2:    rd_data[N_PADS-1:0] = status;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept && !reg_we_i) ? rd_data : '0;
      if (accept && reg_we_i && (reg_addr_i == 2'd1) && reg_wdata_i[0]) begin
        lock_q <= 1'b1;
      end
    end
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;

  for (genvar p = 0; p < 32 / 2; p++) begin : g_pend_pad
    if (p >= N_PADS) begin : g_unused
      assign pend_all[2*p +: 2] = 2'b00;
    end
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    pad_st_e     state_q;
    logic [1:0]  cur_q;
    logic [1:0]  pend_q;
    logic [3:0]  cnt_q;
    logic [1:0]  new_sel;
    logic        field_ok;
    logic [3:0]  fo;
    logic [3:0]  foe;
    logic [3:0]  fin;
    logic        pout;
    logic        poeb;

    assign new_sel  = reg_wdata_i[2*p +: 2];
    assign field_ok = sel_wr & ({1'b0, new_sel} < NFuncW);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StActive;
        cur_q   <= 2'd0;
        pend_q  <= 2'd0;
        cnt_q   <= 4'd0;
      end else begin
        if (field_ok) begin
          pend_q <= new_sel;
        end
        unique case (state_q)
          StActive: begin
            if (field_ok && (new_sel != cur_q)) begin
              state_q <= StGuard;
              cnt_q   <= GuardLd;
            end
          end
          StGuard: begin
            // Any accepted select write restarts the interval, even one back to cur_q.
            if (field_ok) begin
              cnt_q <= GuardLd;
            end else if (cnt_q == 4'd1) begin
              state_q <= StActive;
              cur_q   <= pend_q;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= StActive;
        endcase
      end
    end

    always_comb begin
      fo  = '0;
      foe = '0;
      fo[N_FUNC-1:0]  = func_out_i[p*N_FUNC +: N_FUNC];
      foe[N_FUNC-1:0] = func_oe_i[p*N_FUNC +: N_FUNC];
    end

    always_comb begin
      fin  = '0;
      pout = 1'b0;
      poeb = 1'b1;
      if (state_q == StActive) begin
        pout       = fo[cur_q];
        poeb       = ~foe[cur_q];
        fin[cur_q] = pad_in_i[p];
      end
    end

    assign func_in_o[p*N_FUNC +: N_FUNC] = fin[N_FUNC-1:0];
    assign pad_out_o[p]                  = pout;
    assign pad_oeb_o[p]                  = poeb;
    assign status[p]                     = (state_q == StGuard);
    assign pend_all[2*p +: 2]            = pend_q;
  end

endmodule

// File: tb/tb_iomux_ctrl.sv
// Directed bench for iomux_ctrl: register accesses checked through a scoreboard queue,
// pad routing checked against a small model of the selected owner per pad.
module tb_iomux_ctrl;

  localparam int NP = 5;
  localparam int NF = 3;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              reg_req;
  logic              reg_we;
  logic [1:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              reg_ack;
  logic [NP*NF-1:0]  func_out;
  logic [NP*NF-1:0]  func_oe;
  logic [NP*NF-1:0]  func_in;
  logic [NP-1:0]     pad_in;
  logic [NP-1:0]     pad_out;
  logic [NP-1:0]     pad_oeb;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  iomux_ctrl #(.N_PADS(NP), .N_FUNC(NF), .GUARD_CYC(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_req_i   (reg_req),
    .reg_we_i    (reg_we),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .reg_ack_o   (reg_ack),
    .func_out_i  (func_out),
    .func_oe_i   (func_oe),
    .func_in_o   (func_in),
    .pad_in_i    (pad_in),
    .pad_out_o   (pad_out),
    .pad_oeb_o   (pad_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind 0: pad_out, 1: pad_oeb, 2: func_in; sel holds the owner per pad, grd the guard flags
  function automatic logic [31:0] model(input int kind, input logic [31:0] sel,
                                        input logic [NP-1:0] grd);
    logic [31:0] r = '0;
    for (int p = 0; p < NP; p++) begin
      int idx = p * NF + int'(sel[2*p +: 2]);
      if (kind == 1) r[p] = grd[p] ? 1'b1 : ~func_oe[idx];
      else if (!grd[p]) begin
        if (kind == 0) r[p] = func_out[idx];
        else r[idx] = pad_in[p];
      end
    end
    return r;
  endfunction

  task automatic check_pads(input string tag, input logic [31:0] sel, input logic [NP-1:0] grd);
    chk({tag, "_out"}, 32'(pad_out), model(0, sel, grd));
    chk({tag, "_oeb"}, 32'(pad_oeb), model(1, sel, grd));
    chk({tag, "_fin"}, 32'(func_in), model(2, sel, grd));
  endtask

  // Drives one access from a negedge and returns at the negedge where ack is seen.
  task automatic reg_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string tag);
    logic        got = 1'b0;
    logic [31:0] e;
    exp_q.push_back(exp);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (reg_ack === 1'b1) got = 1'b1;
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) chk({tag, "_rdata"}, reg_rdata, e);
    reg_req = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    reg_req   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = '0;
    func_out  = 15'h5A2C;
    func_oe   = 15'h2E9D;
    pad_in    = 5'b01010;

    #7;
    check_pads("rst", 32'h0, 5'b00000);
    chk("rst_ack", 32'(reg_ack), 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    reg_access(1'b0, 2'd0, 32'h0, 32'h0, "rd_sel0");
    reg_access(1'b0, 2'd2, 32'h0, 32'h0, "rd_stat0");

    // pad1 -> f1: four guard cycles, then the new owner
    reg_access(1'b1, 2'd0, 32'h4, 32'h0, "wr_p1");
    check_pads("p1_g1", 32'h0, 5'b00010);
    reg_access(1'b0, 2'd2, 32'h0, 32'h2, "p1_stat");
    check_pads("p1_g3", 32'h0, 5'b00010);
    @(negedge clk);
    check_pads("p1_g4", 32'h0, 5'b00010);
    @(negedge clk);
    check_pads("p1_act", 32'h4, 5'b00000);

    // out-of-range field for pad2 is dropped
    reg_access(1'b1, 2'd0, 32'h34, 32'h0, "wr_bad");
    check_pads("bad", 32'h4, 5'b00000);
    reg_access(1'b0, 2'd0, 32'h0, 32'h4, "rd_sel_bad");
    reg_access(1'b0, 2'd2, 32'h0, 32'h0, "rd_stat_bad");

    // pad0 -> f2, then -> f1 during guard: interval restarts, f2 never drives
    reg_access(1'b1, 2'd0, 32'h6, 32'h0, "wr_p0a");
    check_pads("p0_g1", 32'h4, 5'b00001);
    reg_access(1'b1, 2'd0, 32'h5, 32'h0, "wr_p0b");
    check_pads("p0_rl", 32'h4, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_pads("p0_g", 32'h4, 5'b00001);
    end
    @(negedge clk);
    check_pads("p0_act", 32'h5, 5'b00000);

    // lock blocks select writes and cannot be cleared by software
    reg_access(1'b1, 2'd1, 32'h1, 32'h0, "wr_lock");
    reg_access(1'b1, 2'd0, 32'h3FF, 32'h0, "wr_sel_l1");
    reg_access(1'b1, 2'd0, 32'h0A0, 32'h0, "wr_sel_l2");
    reg_access(1'b0, 2'd0, 32'h0, 32'h5, "rd_sel_l");
    reg_access(1'b0, 2'd2, 32'h0, 32'h0, "rd_stat_l");
    check_pads("lock", 32'h5, 5'b00000);
    reg_access(1'b1, 2'd1, 32'h0, 32'h0, "wr_lock0");
    reg_access(1'b0, 2'd1, 32'h0, 32'h1, "rd_lock1");
    reg_access(1'b1, 2'd3, 32'hFFFF, 32'h0, "wr_rsv");
    reg_access(1'b0, 2'd3, 32'h0, 32'h0, "rd_rsv");

    rst_ni = 1'b0;
    #1;
    check_pads("rst2", 32'h0, 5'b00000);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    reg_access(1'b0, 2'd1, 32'h0, 32'h0, "rd_lock0");
    reg_access(1'b0, 2'd0, 32'h0, 32'h0, "rd_sel_r");

    // reset in the middle of pad3's guard
    reg_access(1'b1, 2'd0, 32'h80, 32'h0, "wr_p3");
    check_pads("p3_g", 32'h0, 5'b01000);
    #2;
    rst_ni = 1'b0;
    #1;
    check_pads("p3_rst", 32'h0, 5'b00000);
    chk("p3_rst_ack", 32'(reg_ack), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    reg_access(1'b0, 2'd2, 32'h0, 32'h0, "rd_stat_r");
    reg_access(1'b0, 2'd0, 32'h0, 32'h0, "rd_sel_r2");
    check_pads("final", 32'h0, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomux_ctrl.md
Name: iomux_ctrl

Overview:
- Runtime pin-mux controller for the shared user-area IO pads, where one pad can serve GPIO, an SPI slave-select or a PWM output.
- Holds one function-select field per shared pad, written through a simple register port, and routes the selected function's out/oe/in to the pad.
- When a pad changes owner, it is tri-stated for a guard interval so two functions never drive it in consecutive cycles.
- Sits between the SoC peripheral outputs and the io_out/io_oeb/io_in pad vectors.

Parameters:
N_PADS, 5, number of shared pads (1..16)
N_FUNC, 3, functions per pad (2..4); function 0 = GPIO
GUARD_CYC, 4, tri-state cycles on an owner change (1..15)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
reg_req_i  input  1  register access strobe
reg_we_i  input  1  1 = write, 0 = read
reg_addr_i  input  2  word address
reg_wdata_i  input  32  write data
reg_rdata_o  output  32  read data, valid with ack
reg_ack_o  output  1  one-cycle access acknowledge
func_out_i  input  N_PADS*N_FUNC  function outputs, index p*N_FUNC+f
func_oe_i  input  N_PADS*N_FUNC  function output enables, active-high
func_in_o  output  N_PADS*N_FUNC  pad input routed to functions
pad_in_i  input  N_PADS  pad input
pad_out_o  output  N_PADS  pad output
pad_oeb_o  output  N_PADS  pad output enable, active-low

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - cur_sel = pend_sel = 0 for all pads; every pad in ACTIVE; lock = 0.
  - reg_ack_o = 0, reg_rdata_o = 0.
  - Pads follow GPIO immediately: pad_out/pad_oeb track func_out/func_oe of function 0.
- Register map (word addresses):
  - 0 SEL: bits [2p+1:2p] = pend_sel of pad p; read returns pend_sel.
  - 1 LOCK: bit0, set-only; write 0 has no effect; cleared only by reset.
  - 2 STATUS: read-only; bit p = pad p in GUARD.
  - 3 reserved: reads 0, writes ignored.
- Register handshake:
  - reg_req_i sampled high while reg_ack_o=0 → reg_ack_o=1 next cycle for exactly one cycle; reg_rdata_o valid in that cycle.
  - Back-to-back requests give ack every other cycle; requester holds req until it sees ack.
  - reg_rdata_o = 0 on writes.
- SEL write rules:
  - Ignored entirely when lock=1 (still acked).
  - Per pad, a field ≥ N_FUNC is ignored; that pad keeps its pend_sel.
  - Fields for p ≥ N_PADS are ignored.
- Per-pad FSM, ACTIVE/GUARD:
  - ACTIVE: pad_out = func_out[cur], pad_oeb = ~func_oe[cur], func_in[cur] = pad_in, all other func_in of the pad = 0.
  - ACTIVE → GUARD in the cycle after the accepting edge, when the new pend_sel ≠ cur_sel; guard counter loads GUARD_CYC. A write with the same value causes no transition.
  - GUARD: pad_oeb = 1, pad_out = 0, all func_in of the pad = 0; counter decrements each cycle.
  - GUARD exits when the counter reaches 0: cur_sel ← pend_sel, back to ACTIVE.
  - Timing: the new owner drives exactly GUARD_CYC cycles after the pad first shows oeb=1.
- Boundary and simultaneous cases:
  - A SEL write during GUARD updates pend_sel and reloads the counter, so the interval restarts.
  - If that write sets pend_sel back to cur_sel, the pad still completes the reloaded guard before returning to ACTIVE.
  - Writes to SEL and LOCK are separate accesses; LOCK applies from the access after it is acked.
  - Reset mid-GUARD: pad returns to GPIO ACTIVE asynchronously.
- Pad outputs are combinational from the registered cur_sel and state; nothing else is registered in the output path.

Test Plan:
- Reset → pad_oeb=~func_oe[f0], reg_ack_o=0, read SEL = 0x000, read STATUS = 0.
- Write SEL=0x004 (pad1→f1) at T → ack at T+1; pad1 oeb=1 and STATUS=0x02 for cycles T+1..T+4; at T+5 pad1 follows func_out[4]/func_oe[4] and func_in[4]=pad_in[1]; pads 0, 2-4 never disturbed.
- Write pad2 field=3 with N_FUNC=3 → pad2 unchanged, no GUARD, read SEL shows the old field.
- Write SEL pad0→f2, then write pad0→f1 two cycles later → guard restarts at the second write's ack+1, and the first f2 output never appears on the pad.
- Write LOCK=1, then SEL=0x3FF → SEL read unchanged, no STATUS bits set; write LOCK=0 → lock stays 1; reset → lock 0.
- Assert rst_ni low mid-GUARD of pad3 → pad3 immediately follows GPIO and STATUS=0 after reset.
